// File: rtl/pc_stepper_pkg.sv
// Shared types and constants for the PC stepping stage.
//   state_e     : stepper FSM states
//   STEP_CNT_W  : width of the step counter output
//   addr_lsb_w  : number of low address bits cleared on load (log2 of step)
package pc_stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned STEP_CNT_W = 16;

  function automatic int unsigned addr_lsb_w(input int unsigned step);
    return $clog2(step);
  endfunction

endpackage

// File: rtl/pc_stepper_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for the divider tick.
//   clk  : system clock
//   rst  : synchronous active-high reset (clears all flops)
//   d    : asynchronous input level
//   rise : one-cycle pulse per low->high transition of d
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync0_q, sync1_q, prev_q, valid_q, armed_q;
  logic sync0_d, sync1_d, prev_d, valid_d, armed_d;

  // valid: sync0 holds a real sample (not the reset value).
  // armed: a genuine low level has been sampled since reset, so an input
  // that is already high at reset release does not count as a rising edge.
  always_comb begin
    sync0_d = d;
    sync1_d = sync0_q;
    prev_d  = sync1_q;
    valid_d = 1'b1;
    armed_d = armed_q | (valid_q & ~sync0_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
    end
  end

  assign rise = sync1_q & ~prev_q & armed_q;

endmodule

// File: rtl/pc_stepper.sv
// Program-counter stepper driven by rising edges of a slow divider tick.
//   clk, rst     : system clock, synchronous active-high reset
//   tick_in      : asynchronous divider level; each rising edge is one step
//   run          : level, enables stepping
//   load         : one-cycle request to load load_addr (step-aligned)
//   load_addr    : load target, low log2(PC_STEP) bits forced to zero
//   pc           : current program counter
//   fetch_valid  : one-cycle pulse in the cycle after every PC change
//   halted       : high while stopped at the limit (no-wrap mode)
//   step_count   : number of edge-driven PC changes since reset
module pc_stepper
  import pc_stepper_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned PC_LIMIT = 252,
  parameter int unsigned RESET_PC = 0,
  parameter bit          WRAP_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  run,
  input  logic                  load,
  input  logic [PC_WIDTH-1:0]   load_addr,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  fetch_valid,
  output logic                  halted,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam int unsigned          LSB_W     = addr_lsb_w(PC_STEP);
  localparam logic [PC_WIDTH-1:0]  ADDR_MASK = {PC_WIDTH{1'b1}} << LSB_W;
  localparam logic [PC_WIDTH-1:0]  LIMIT_V   = PC_WIDTH'(PC_LIMIT);
  localparam logic [PC_WIDTH-1:0]  RESET_V   = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0]  STEP_V    = PC_WIDTH'(PC_STEP);

  logic tick_rise;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (tick_in),
    .rise (tick_rise)
  );

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic                    halted_q, halted_d;
  logic [STEP_CNT_W-1:0]   step_count_q, step_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = 1'b0;
    step_count_d  = step_count_q;

    if (load) begin
      // A same-cycle tick edge is consumed here and never stepped.
      pc_d          = load_addr & ADDR_MASK;
      fetch_valid_d = 1'b1;
      state_d       = run ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick_rise) begin
            if (pc_q >= LIMIT_V) begin
              if (WRAP_EN) begin
                pc_d          = RESET_V;
                fetch_valid_d = 1'b1;
                step_count_d  = step_count_q + STEP_CNT_W'(1);
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              pc_d          = pc_q + STEP_V;
              fetch_valid_d = 1'b1;
              step_count_d  = step_count_q + STEP_CNT_W'(1);
            end
          end
          // Halting takes precedence over dropping back to idle.
          if (!run && state_d != ST_DONE) state_d = ST_IDLE;
        end
        ST_DONE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    halted_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_V;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      step_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
      step_count_q  <= step_count_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign step_count  = step_count_q;

endmodule
